// File: rtl/wrr_arbiter_4.sv
// Four-port weighted round-robin arbiter: the owner holds the grant for up to
// weight[owner] accepted beats, then priority rotates past it with no idle cycle.
module wrr_arbiter_4 #(
  parameter int WW = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req,
  input  logic [4*WW-1:0] weight,
  input  logic            ack,
  output logic [3:0]      gnt,
  output logic [1:0]      gnt_idx,
  output logic            valid,
  output logic [WW-1:0]   credit
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    gnt_idx_q, gnt_idx_d;
  logic          valid_q, valid_d;
  logic [WW-1:0] credit_q, credit_d;

  logic [3:0]    eligible;
  logic [1:0]    scan_ptr;
  logic [1:0]    win_idx;
  logic          win_found;
  logic [WW-1:0] win_weight;
  logic          release_now;

  // A zero weight disables a port even while it requests.
  for (genvar gi = 0; gi < 4; gi++) begin : g_elig
    assign eligible[gi] = req[gi] && (weight[gi*WW +: WW] != '0);
  end

  // On release the scan starts just past the current owner, so the owner is
  // considered last and only wins again when nobody else is eligible.
  assign release_now = (state_q == GRANT) &&
                       (!req[gnt_idx_q] || (ack && (credit_q == WW'(1))));
  assign scan_ptr    = (state_q == GRANT) ? (gnt_idx_q + 2'd1) : ptr_q;

  always_comb begin
    logic [1:0] idx;
    win_found = 1'b0;
    win_idx   = scan_ptr;
    idx       = scan_ptr;
    for (int k = 0; k < 4; k++) begin
      idx = scan_ptr + 2'(k);
      if (!win_found && eligible[idx]) begin
        win_found = 1'b1;
        win_idx   = idx;
      end
    end
  end

  assign win_weight = weight[win_idx*WW +: WW];

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gnt_d     = gnt_q;
    gnt_idx_d = gnt_idx_q;
    valid_d   = valid_q;
    credit_d  = credit_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = GRANT;
          gnt_d     = 4'b0001 << win_idx;
          gnt_idx_d = win_idx;
          valid_d   = 1'b1;
          credit_d  = win_weight;
        end
      end
      GRANT: begin
        if (release_now) begin
          ptr_d = gnt_idx_q + 2'd1;
          if (win_found) begin
            gnt_d     = 4'b0001 << win_idx;
            gnt_idx_d = win_idx;
            valid_d   = 1'b1;
            credit_d  = win_weight;
          end else begin
            state_d   = IDLE;
            gnt_d     = '0;
            gnt_idx_d = '0;
            valid_d   = 1'b0;
            credit_d  = '0;
          end
        end else if (ack && (credit_q > WW'(1))) begin
          credit_d = credit_q - WW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= '0;
      gnt_q     <= '0;
      gnt_idx_q <= '0;
      valid_q   <= 1'b0;
      credit_q  <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      gnt_q     <= gnt_d;
      gnt_idx_q <= gnt_idx_d;
      valid_q   <= valid_d;
      credit_q  <= credit_d;
    end
  end

  assign gnt     = gnt_q;
  assign gnt_idx = gnt_idx_q;
  assign valid   = valid_q;
  assign credit  = credit_q;

endmodule
